// File: rtl/pkt_proto_pkg.sv
// Shared packet-protocol definitions for the frame transmitter and receiver buffer.
// State encodings, default geometry and a small counter-width helper.
package pkt_proto_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  localparam int PKT_W_DEF    = 4;
  localparam int NUM_PKTS_DEF = 4;
  localparam int IDLE_GAP_DEF = 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkt_frame_transmitter_if.sv
// Frame-source and packet-stream interfaces around the frame transmitter.
// Master drives the transfer, slave accepts it.
interface pkt_frame_if import pkt_proto_pkg::*; #(
  parameter int PKT_W    = PKT_W_DEF,
  parameter int NUM_PKTS = NUM_PKTS_DEF
);
  logic [PKT_W*NUM_PKTS-1:0] frame_data;
  logic                      frame_valid;
  logic                      frame_ready;
  logic                      abort;
  logic                      frame_done;

  modport master (output frame_data, frame_valid, abort,
                  input  frame_ready, frame_done);
  modport slave  (input  frame_data, frame_valid, abort,
                  output frame_ready, frame_done);
endinterface

interface pkt_data_if import pkt_proto_pkg::*; #(
  parameter int PKT_W = PKT_W_DEF
);
  logic [PKT_W-1:0] data_pkt;
  logic             pkt_valid;
  logic             pkt_ready;
  logic             last_data_packet;

  modport master (output data_pkt, pkt_valid, last_data_packet,
                  input  pkt_ready);
  modport slave  (input  data_pkt, pkt_valid, last_data_packet,
                  output pkt_ready);
endinterface

// File: rtl/pkt_gap_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module pkt_gap_timer #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/pkt_frame_transmitter.sv
// Serialises a frame word into PKT_W-wide packets on a valid/ready stream.
// Build option PKT_TX_MSB_FIRST_EN: send the highest slice first instead of the lowest.
//
// state | meaning
// IDLE  | ready for a frame, no packet presented
// SEND  | presenting packet pkt_idx, waiting for pkt_ready
// GAP   | enforced idle time after the last packet of a frame
module pkt_frame_transmitter import pkt_proto_pkg::*; #(
  parameter int PKT_W    = PKT_W_DEF,
  parameter int NUM_PKTS = NUM_PKTS_DEF,
  parameter int IDLE_GAP = IDLE_GAP_DEF
) (
  input logic         clock,
  input logic         reset,
  pkt_frame_if.slave  frm,
  pkt_data_if.master  pkt
);
  localparam int FRAME_W = PKT_W * NUM_PKTS;
  localparam int IDX_W   = idx_width(NUM_PKTS);
  localparam int GAP_W   = idx_width(IDLE_GAP + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PKTS - 1);
  // Timer runs load..0 inclusive, so loading IDLE_GAP-1 gives IDLE_GAP cycles.
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
`ifdef PKT_TX_MSB_FIRST_EN
  localparam int FIRST_SLICE = NUM_PKTS - 1;
`else
  localparam int FIRST_SLICE = 0;
`endif

  tx_state_e          state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PKT_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic               gap_load, gap_dec, gap_done;
  logic [IDX_W-1:0]   next_idx, next_sel;
  logic [PKT_W-1:0]   slices [NUM_PKTS];

  for (genvar k = 0; k < NUM_PKTS; k++) begin : g_slice
    assign slices[k] = frame_q[k*PKT_W +: PKT_W];
  end

  assign next_idx = idx_q + 1'b1;
`ifdef PKT_TX_MSB_FIRST_EN
  assign next_sel = LAST_IDX - next_idx;
`else
  assign next_sel = next_idx;
`endif

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frm.frame_valid) begin
          frame_d = frm.frame_data;
          idx_d   = '0;
          data_d  = frm.frame_data[FIRST_SLICE*PKT_W +: PKT_W];
          valid_d = 1'b1;
          last_d  = (LAST_IDX == '0);
          state_d = SEND;
        end
      end
      SEND: begin
        // Abort takes priority over a handshake in the same cycle.
        if (frm.abort) begin
          idx_d   = '0;
          data_d  = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end else if (pkt.pkt_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            if (IDLE_GAP > 0) begin
              gap_load = 1'b1;
              state_d  = GAP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d  = next_idx;
            data_d = slices[next_sel];
            last_d = (next_idx == LAST_IDX);
          end
        end
      end
      GAP: begin
        gap_dec = 1'b1;
        if (gap_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  pkt_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .dec_i      (gap_dec),
    .done_o     (gap_done)
  );

  assign frm.frame_ready      = (state_q == IDLE) && reset;
  assign frm.frame_done       = done_q;
  assign pkt.data_pkt         = data_q;
  assign pkt.pkt_valid        = valid_q;
  assign pkt.last_data_packet = last_q;

endmodule

// File: tb/tb_pkt_frame_transmitter.sv
// Bench for pkt_frame_transmitter: a basic-send vector table, directed corner
// sequences and random traffic, all checked against a packet-queue model.
module tb_pkt_frame_transmitter;
  import pkt_proto_pkg::*;

  localparam int PW = 4;
  localparam int NP = 4;
  localparam int IG = 1;
  localparam int FW = PW * NP;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pkt_frame_if #(.PKT_W(PW), .NUM_PKTS(NP)) fif ();
  pkt_data_if  #(.PKT_W(PW))                pif ();

  pkt_frame_transmitter #(.PKT_W(PW), .NUM_PKTS(NP), .IDLE_GAP(IG)) dut (
    .clock (clock),
    .reset (reset),
    .frm   (fif.slave),
    .pkt   (pif.master)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Model: packets still to send (head = presented), gap cycles left, done pulse.
  logic [PW-1:0] m_q[$];
  int            m_gap = 0;
  bit            m_done = 1'b0;

  typedef struct {
    bit            fv;
    logic [FW-1:0] fd;
    bit            ab;
    bit            pr;
    bit            e_ready;
    bit            e_valid;
    logic [PW-1:0] e_data;
    bit            e_last;
    bit            e_done;
  } vec_t;

  vec_t          tbl[6];
  logic [PW-1:0] ord[4];

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_gap  = 0;
    m_done = 1'b0;
  endfunction

  function automatic void model_step(bit fv, logic [FW-1:0] fd, bit ab, bit pr);
    m_done = 1'b0;
    if (m_q.size() > 0) begin
      if (ab) begin
        m_q.delete();
      end else if (pr) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_done = 1'b1;
          m_gap  = IG;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (fv) begin
      for (int k = 0; k < NP; k++) begin
        int s;
`ifdef PKT_TX_MSB_FIRST_EN
        s = NP - 1 - k;
`else
        s = k;
`endif
        m_q.push_back(fd[s*PW +: PW]);
      end
    end
  endfunction

  function automatic void check_outputs(string tag);
    bit busy;
    busy = (m_q.size() > 0);
    chk({tag, ".frame_ready"}, int'(fif.frame_ready), int'(!busy && m_gap == 0));
    chk({tag, ".pkt_valid"},   int'(pif.pkt_valid), int'(busy));
    chk({tag, ".data_pkt"},    int'(pif.data_pkt), busy ? int'(m_q[0]) : 0);
    chk({tag, ".last"},        int'(pif.last_data_packet), int'(busy && m_q.size() == 1));
    chk({tag, ".frame_done"},  int'(fif.frame_done), int'(m_done));
  endfunction

  task automatic step(bit fv, logic [FW-1:0] fd, bit ab, bit pr, string tag);
    fif.frame_valid = fv;
    fif.frame_data  = fd;
    fif.abort       = ab;
    pif.pkt_ready   = pr;
    @(posedge clock);
    model_step(fv, fd, ab, pr);
    @(negedge clock);
    check_outputs(tag);
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while ((m_q.size() > 0 || m_gap > 0) && n < 32) begin
      step(1'b0, '0, 1'b0, 1'b1, tag);
      n++;
    end
    chk({tag, ".bounded"}, int'(n < 32), 1);
  endtask

  initial begin
    int   n;
    int   zeros;
    int   nacc;
    bit   idle;
    bit   prev_v;
    int   rise[$];

    fif.frame_valid = 1'b0;
    fif.frame_data  = '0;
    fif.abort       = 1'b0;
    pif.pkt_ready   = 1'b0;
    model_reset();

    // Outputs while reset is held
    #12;
    chk("rst.frame_ready", int'(fif.frame_ready), 0);
    chk("rst.pkt_valid",   int'(pif.pkt_valid), 0);
    chk("rst.data_pkt",    int'(pif.data_pkt), 0);
    chk("rst.frame_done",  int'(fif.frame_done), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_release.frame_ready", int'(fif.frame_ready), 1);
    @(negedge clock);

    // Basic send table
`ifdef PKT_TX_MSB_FIRST_EN
    ord = '{4'hA, 4'h5, 4'hC, 4'h3};
`else
    ord = '{4'h3, 4'hC, 4'h5, 4'hA};
`endif
    tbl[0] = '{1'b1, 16'hA5C3, 1'b0, 1'b1, 1'b0, 1'b1, ord[0], 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, ord[1], 1'b0, 1'b0};
    tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, ord[2], 1'b0, 1'b0};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, ord[3], 1'b1, 1'b0};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0,   1'b0, 1'b1};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0,   1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].fv, tbl[i].fd, tbl[i].ab, tbl[i].pr, "basic");
      chk("tbl.frame_ready", int'(fif.frame_ready),      int'(tbl[i].e_ready));
      chk("tbl.pkt_valid",   int'(pif.pkt_valid),        int'(tbl[i].e_valid));
      chk("tbl.data_pkt",    int'(pif.data_pkt),         int'(tbl[i].e_data));
      chk("tbl.last",        int'(pif.last_data_packet), int'(tbl[i].e_last));
      chk("tbl.frame_done",  int'(fif.frame_done),       int'(tbl[i].e_done));
    end

    // Backpressure while packet 5 is presented
    step(1'b1, 16'hA5C3, 1'b0, 1'b1, "bp");
    n = 0;
    while (m_q.size() > 0 && m_q[0] != 4'h5 && n < 8) begin
      step(1'b0, '0, 1'b0, 1'b1, "bp");
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, "bp_hold");
      chk("bp.hold_data",  int'(pif.data_pkt), 5);
      chk("bp.hold_valid", int'(pif.pkt_valid), 1);
    end
    drain("bp_drain");

    // Back-to-back frames with frame_valid held high
    zeros  = 0;
    nacc   = 0;
    prev_v = 1'b0;
    for (int s = 0; s < 12; s++) begin
      idle = (m_q.size() == 0 && m_gap == 0);
      step(1'b1, (nacc == 0) ? 16'h1234 : 16'h5678, 1'b0, 1'b1, "b2b");
      if (idle) nacc++;
      if (s < 6 && !fif.frame_ready) zeros++;
      if (pif.pkt_valid && !prev_v) rise.push_back(s);
      prev_v = pif.pkt_valid;
    end
    chk("b2b.ready_low_cycles", zeros, 5);
    chk("b2b.first_pkt_spacing", (rise.size() >= 2) ? rise[1] - rise[0] : -1, 6);
    drain("b2b_drain");

    // Abort on packet 2, coincident with a handshake
    step(1'b1, 16'hFFFF, 1'b0, 1'b1, "ab");
    step(1'b0, '0, 1'b0, 1'b1, "ab");
    step(1'b0, '0, 1'b0, 1'b1, "ab");
    step(1'b0, '0, 1'b1, 1'b1, "ab_hit");
    chk("abort.pkt_valid",   int'(pif.pkt_valid), 0);
    chk("abort.frame_ready", int'(fif.frame_ready), 1);
    chk("abort.frame_done",  int'(fif.frame_done), 0);
    step(1'b0, '0, 1'b0, 1'b1, "ab_after");
    chk("abort.no_done_late", int'(fif.frame_done), 0);
    // abort while idle does not block acceptance
    step(1'b1, 16'hBEEF, 1'b1, 1'b1, "ab_idle");
    chk("abort_idle.accepted", int'(pif.pkt_valid), 1);
    drain("ab_drain");

    // Asynchronous reset mid-frame
    step(1'b1, 16'h1234, 1'b0, 1'b1, "ar");
    step(1'b0, '0, 1'b0, 1'b1, "ar");
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst.pkt_valid",   int'(pif.pkt_valid), 0);
    chk("async_rst.last",        int'(pif.last_data_packet), 0);
    chk("async_rst.data_pkt",    int'(pif.data_pkt), 0);
    chk("async_rst.frame_ready", int'(fif.frame_ready), 0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    step(1'b1, 16'h0F0F, 1'b0, 1'b1, "ar_next");
`ifndef PKT_TX_MSB_FIRST_EN
    chk("ar_next.first", int'(pif.data_pkt), 15);
`endif
    drain("ar_drain");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), FW'($urandom), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), "rand");
    end
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pkt_frame_transmitter.md
Name: pkt_frame_transmitter

Overview:
Transmit-side counterpart of the packet data buffer.
- Accepts a full frame word and serialises it into fixed-width data packets on a valid/ready packet interface.
- Flags the final packet of each frame with last_data_packet, so the downstream receiver knows when to capture the assembled frame.
- Sits between a frame source (register file or testbench driver) and the packet receiver/buffer.

Parameters:
PKT_W, 4, width of one data packet in bits
NUM_PKTS, 4, packets per frame (must be >= 1)
IDLE_GAP, 1, idle cycles enforced after the last packet of a frame before the next frame is accepted (0 allowed)

Ports:
clock  input  1  clock, rising-edge active
reset  input  1  asynchronous, active-low reset
frame_data  input  PKT_W*NUM_PKTS  frame to send; packet k is bits [k*PKT_W +: PKT_W]
frame_valid  input  1  frame_data is valid
frame_ready  output  1  block can accept a frame this cycle
abort  input  1  synchronous cancel of the frame in flight
data_pkt  output  PKT_W  current packet
pkt_valid  output  1  data_pkt is valid
pkt_ready  input  1  receiver accepts data_pkt this cycle
last_data_packet  output  1  current packet is the last of the frame (qualified by pkt_valid)
frame_done  output  1  one-cycle pulse: a frame completed without abort

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - Outputs: pkt_valid=0, last_data_packet=0, data_pkt=0, frame_done=0, frame_ready=0 while reset is asserted, then 1 on the first cycle in IDLE.
  - Shift register and counters are cleared. A frame in flight is discarded with no frame_done.
- All outputs are registered, except frame_ready, which is decoded from state.
- States:
  - IDLE: frame_ready=1, pkt_valid=0. On frame_valid&&frame_ready: latch frame_data, set pkt_idx=0, go to SEND.
  - SEND: pkt_valid=1; data_pkt = slice pkt_idx; last_data_packet = (pkt_idx==NUM_PKTS-1).
    - On pkt_valid&&pkt_ready with a non-last packet: pkt_idx++.
    - On the last packet: go to GAP if IDLE_GAP>0, otherwise IDLE. Pulse frame_done in the following cycle.
  - GAP: pkt_valid=0, frame_ready=0; count IDLE_GAP cycles, then go to IDLE.
- Latency:
  - Frame accepted at edge N → first packet valid from edge N+1.
  - With pkt_ready held high, one packet per cycle.
  - Minimum frame period is NUM_PKTS + IDLE_GAP + 1 cycles.
- Handshake rules:
  - While pkt_valid=1 and pkt_ready=0, data_pkt and last_data_packet hold stable.
  - pkt_valid never drops without a handshake, except on abort or reset.
- data_pkt is driven to 0 whenever pkt_valid=0.
- NUM_PKTS=1: the single packet carries last_data_packet=1.
- abort:
  - In SEND: go to IDLE at the next edge, pkt_valid=0, no frame_done. abort wins over a simultaneous handshake.
  - In IDLE or GAP: ignored. An IDLE frame_valid in the same cycle is still accepted.
- pkt_idx counter width is clog2(NUM_PKTS), minimum 1. It never wraps past NUM_PKTS-1.

Optional Feature:
Macro PKT_TX_MSB_FIRST_EN.
- Defined: packets are sent highest slice first (slice NUM_PKTS-1 down to slice 0); last_data_packet is on slice 0.
- Undefined: packets are sent lowest slice first (slice 0 up to NUM_PKTS-1).
- Handshake, timing and ports are identical in both builds.

Decomposition:
- Package pkt_proto_pkg holds:
  - state encodings IDLE=2'd0, SEND=2'd1, GAP=2'd2;
  - the default PKT_W and NUM_PKTS constants, shared with the receiver buffer.
- One sub-module: pkt_gap_timer. It is a loadable down-counter with a done flag, reused for the IDLE_GAP wait.
- Slice selection stays inline.

Test Plan:
- Basic send (defaults, macro off): frame_data=16'hA5C3, pkt_ready=1 → data_pkt 3,C,5,A on 4 consecutive cycles; last_data_packet=1 only with A; frame_done pulses 1 cycle later.
- MSB-first (macro on): frame_data=16'hA5C3 → A,5,C,3; last_data_packet with 3.
- Backpressure: pkt_ready=0 for 3 cycles while packet 5 is presented → data_pkt holds 4'h5 with pkt_valid=1; sequence completes unchanged after pkt_ready returns.
- Back-to-back frames, IDLE_GAP=1: frame_valid held high with 16'h1234 then 16'h5678 → frame_ready=0 for 5 cycles; second frame's first packet appears exactly 6 cycles after the first frame's first packet.
- Abort on packet 2 of 16'hFFFF, coincident with pkt_ready=1 → pkt_valid=0 next cycle, no frame_done, frame_ready=1.
- Async reset mid-frame (reset low between edges during packet 1) → pkt_valid, last_data_packet, data_pkt drop to 0 immediately; after release the next frame 16'h0F0F sends 4'hF,0,F,0 correctly.
